write_back_queue: RTL

WRITE_BACK_QUEUE -- requirements
Module: write_back_queue

---
 rtl/write_back_queue.sv | 122 ++++++++++++
 1 files changed

// File: rtl/write_back_queue.sv
// rtl/write_back_queue.sv - write-back queue merging ALU and load results into one register-file write port
// FIFO of {addr, data} entries drained one per cycle into a registered write port, with pending-write flags.
module write_back_queue #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_alu_v,
    input  logic [4:0]  i_alu_a,
    input  logic [31:0] i_alu_d,
    input  logic        i_lnk_v,
    input  logic [31:0] i_pcf,
    input  logic        i_mem_v,
    input  logic [4:0]  i_mem_a,
    input  logic [31:0] i_mem_d,
    output logic        o_alu_rdy,
    output logic        o_mem_rdy,
    output logic        o_we3,
    output logic [4:0]  o_a3,
    output logic [31:0] o_wd3,
    output logic [31:0] o_busy,
    output logic [2:0]  o_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = 3;

    logic [4:0]    r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_we3;
    logic [4:0]    r_a3;
    logic [31:0]   r_wd3;

    logic [CW-1:0] w_free;
    logic          w_mem_rdy;
    logic          w_alu_rdy;
    logic [4:0]    w_alu_a;
    logic [31:0]   w_alu_d;
    logic          w_mem_push;
    logic          w_alu_push;
    logic          w_pop;
    logic [AW-1:0] w_npush;
    logic [AW-1:0] w_alu_slot;
    logic [CW-1:0] w_cnt_next;
    logic [AW-1:0] w_off;
    logic [31:0]   w_busy;

    // Free space is judged on start-of-cycle occupancy; the head popped this edge does not help.
    assign w_free    = CW'(DEPTH) - r_cnt;
    assign w_mem_rdy = (w_free != '0);
    assign w_alu_rdy = i_mem_v ? (w_free >= CW'(2)) : (w_free != '0);

    assign w_alu_a = i_lnk_v ? 5'd31 : i_alu_a;
    assign w_alu_d = i_lnk_v ? (i_pcf + 32'd1) : i_alu_d;

    // Writes to r0 are acknowledged but never enqueued.
    assign w_mem_push = i_mem_v & w_mem_rdy & (i_mem_a != 5'd0);
    assign w_alu_push = i_alu_v & w_alu_rdy & (w_alu_a != 5'd0);
    assign w_pop      = (r_cnt != '0);

    assign w_npush    = {{(AW-1){1'b0}}, w_mem_push} + {{(AW-1){1'b0}}, w_alu_push};
    assign w_alu_slot = r_wr_ptr + {{(AW-1){1'b0}}, w_mem_push};
    assign w_cnt_next = r_cnt + {{(CW-1){1'b0}}, w_mem_push} + {{(CW-1){1'b0}}, w_alu_push}
                      - {{(CW-1){1'b0}}, w_pop};

    always_ff @(posedge i_clk) begin
        if (w_mem_push) begin
            r_addr[r_wr_ptr] <= i_mem_a;
            r_data[r_wr_ptr] <= i_mem_d;
        end
        if (w_alu_push) begin
            r_addr[w_alu_slot] <= w_alu_a;
            r_data[w_alu_slot] <= w_alu_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_we3    <= 1'b0;
            r_a3     <= 5'd0;
            r_wd3    <= 32'd0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_npush;
            r_cnt    <= w_cnt_next;
            r_we3    <= w_pop;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_a3     <= r_addr[r_rd_ptr];
                r_wd3    <= r_data[r_rd_ptr];
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        w_busy = '0;
        w_off  = '0;
        for (int s = 0; s < DEPTH; s++) begin
            w_off = AW'(s) - r_rd_ptr;
            if ({1'b0, w_off} < r_cnt) begin
                w_busy[r_addr[s]] = 1'b1;
            end
        end
        if (r_we3) begin
            w_busy[r_a3] = 1'b1;
        end
        w_busy[0] = 1'b0;
    end

    assign o_alu_rdy = w_alu_rdy;
    assign o_mem_rdy = w_mem_rdy;
    assign o_we3     = r_we3;
    assign o_a3      = r_a3;
    assign o_wd3     = r_wd3;
    assign o_busy    = w_busy;
    assign o_cnt     = r_cnt;
endmodule
